ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester controller for the single-port 8-bit synchronous RAM. Two independent clients (A and B) share one RAM port through a round-robin arbiter. An FSM generates the RAM's `cs`/`rw`/`oe` strobes, address and tristate data bus in the cycle-exact pattern the RAM needs for its registered read and its synchronous write. The block sits between the datapath clients and the RAM instance, and is the only driver of the RAM control pins.

## Interface
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 8: RAM address width.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a_req` input 1: A request, level; held with `a_we`/`a_addr`/`a_wdata` stable until `a_ack`.
- `a_we` input 1: 1 = write, 0 = read.
- `a_addr` input ADDR_WIDTH: A address.
- `a_wdata` input DATA_WIDTH: A write data.
- `a_ack` output 1: one-cycle completion pulse for A.
- `a_rdata` output DATA_WIDTH: last data read for A, valid while `a_ack` is high, held until A's next read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical to the A ports, for B.
- `ram_cs` output 1: RAM chip select.
- `ram_rw` output 1: RAM 1 = write, 0 = read.
- `ram_oe` output 1: RAM output enable.
- `ram_addr` output ADDR_WIDTH: RAM address.
- `ram_data` inout DATA_WIDTH: RAM data bus. Driven by this block only in WRITE; high-Z otherwise.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, WRITE, READ1, READ2.
- **IDLE behaviour:**
  - Outputs: `ram_cs`=0, `ram_oe`=0, `ram_rw`=0; `ram_data` is Z.
  - Eligible requester: `x_req`=1 and `x_ack`=0. The ack mask stops a requester from being re-granted on its stale `req` in the cycle after its own ack.
  - Arbitration:
    - One eligible requester: grant it.
    - Both eligible: grant the one that is not `last_grant`.
    - `last_grant` resets to B, so A wins the first tie.
  - On grant, at the clock edge:
    - Capture `we`, `addr` and `wdata` into internal registers.
    - Record the granted id.
    - Update `last_grant`.
    - Next state is WRITE if `we`=1, otherwise READ1.
- **WRITE:**
  - Outputs: `ram_cs`=1, `ram_rw`=1, `ram_oe`=0, `ram_addr` = captured address, `ram_data` = captured wdata.
  - The RAM commits on the next edge. At that edge, set the granted `x_ack` and go to IDLE.
- **READ1:**
  - Outputs: `ram_cs`=1, `ram_oe`=1, `ram_rw`=0, `ram_addr` = captured address; `ram_data` is Z.
  - The RAM latches its output register on the next edge. Go to READ2.
- **READ2:**
  - Outputs: same strobes and address as READ1. The RAM drives `ram_data`.
  - At the next edge: `x_rdata` <= `ram_data`, set `x_ack`, go to IDLE.
- **Strobe and data sourcing:**
  - RAM strobes and `ram_data` enable are decoded combinationally from the state register and the captured registers.
  - Requester input changes during a transaction have no effect.
- **Ack pulse:** `x_ack` is registered, high for exactly one cycle (the IDLE cycle after completion), and never high for both requesters at once.
- **Reset:** `rst` high forces, immediately and independent of `clk`:
  - state IDLE;
  - `ram_cs`=`ram_rw`=`ram_oe`=0 and `ram_data` Z;
  - `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, `busy`=0;
  - `last_grant`=B;
  - captured registers = 0.

## Timing
- Grant edge is t0.
- **Write:** RAM commit at t1; ack high t1–t2; next grant to the same requester no earlier than t3. Throughput is 3 cycles per write.
- **Read:** RAM latch at t1; rdata capture at t2; ack high t2–t3. Throughput is 4 cycles per read.
- A different eligible requester can be granted at the edge that ends the ack cycle, e.g. B at t2 after an A write.
- **Reset mid-transaction:**
  - Strobes drop combinationally, so the RAM sees no write commit and no ack is issued.
  - The interrupted requester must re-present its request.
- **`busy` timing:** `busy` = (state ≠ IDLE); it rises in the cycle after the grant edge.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → all outputs take reset values without a clock edge; `ram_data` Z.
- **A write then read:**
  - Stimulus: A writes 0x5A to address 0x10, then reads 0x10.
  - `a_ack` one cycle at t1 of the write.
  - Read shows `ram_cs`/`ram_oe` for exactly 2 cycles with `ram_rw`=0.
  - `a_rdata`=0x5A with `a_ack` at t2; `a_rdata` holds 0x5A afterwards.
- **Simultaneous requests after reset:**
  - Stimulus: A and B request together after reset; A writes 0x11 to 0x01, B writes 0x22 to 0x02.
  - A is served first, then B; the two acks never overlap.
  - Read-back gives 0x11 and 0x22.
- **Continuous contention:** both hold `req`, read-only → grants alternate A, B, A, B over 8 transactions with no starvation.
- **Reset during WRITE:**
  - Stimulus: A writes 0xFF to 0x20 over prior content 0x00; `rst` pulses in the WRITE cycle before the commit edge.
  - No `a_ack`.
  - A subsequent read of 0x20 returns 0x00.
- **Bus ownership:**
  - Check across every cycle of a mixed sequence that `ram_data` is driven by this block only while `ram_cs`=1 and `ram_rw`=1, and is never driven while `ram_oe`=1.
  - No X appears on `ram_data` during READ2.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and strobe sequencer that lets two clients share one
// single-port synchronous RAM with a registered read and a synchronous write.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_cs,
    output logic                  ram_rw,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ1 = 2'd2,
        READ2 = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_b_q, last_b_d;
    logic                  gnt_b_q, gnt_b_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic a_elig, b_elig, pick_b;

    // A requester is masked during its own ack cycle so its stale req is not re-granted.
    assign a_elig = a_req && !a_ack_q;
    assign b_elig = b_req && !b_ack_q;
    assign pick_b = b_elig && (!a_elig || !last_b_q);

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        gnt_b_d   = gnt_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (a_elig || b_elig) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? b_we    : a_we;
                    addr_d   = pick_b ? b_addr  : a_addr;
                    wdata_d  = pick_b ? b_wdata : a_wdata;
                    state_d  = (pick_b ? b_we : a_we) ? WRITE : READ1;
                end
            end
            WRITE: begin
                a_ack_d = !gnt_b_q;
                b_ack_d = gnt_b_q;
                state_d = IDLE;
            end
            READ1: begin
                state_d = READ2;
            end
            READ2: begin
                if (gnt_b_q) begin
                    b_rdata_d = ram_data;
                end else begin
                    a_rdata_d = ram_data;
                end
                a_ack_d = !gnt_b_q;
                b_ack_d = gnt_b_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            gnt_b_q   <= gnt_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes come straight from the state register so reset drops them at once.
    assign busy     = (state_q != IDLE);
    assign ram_cs   = busy;
    assign ram_rw   = (state_q == WRITE);
    assign ram_oe   = (state_q == READ1) || (state_q == READ2);
    assign ram_addr = addr_q;
    assign ram_data = (state_q == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM on the bus, table vectors,
// directed corner sequences and two random clients checked against a memory model.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_cs, ram_rw, ram_oe, busy;
    logic [7:0] ram_addr;
    wire  [7:0] ram_data;

    int errors = 0;
    int checks = 0;
    int cnt_rd = 0;
    int cnt_wr = 0;
    bit mon_en = 1'b0;

    logic [7:0] ram_mem [256] = '{default: 8'h00};
    logic [7:0] ram_out_q = 8'h00;
    logic       rd_vld_q = 1'b0;
    logic       ram_drv;
    logic [7:0] model_mem [256];

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM: registered read drives the bus in the cycle after the address is latched.
    assign ram_drv  = ram_cs && ram_oe && !ram_rw && rd_vld_q;
    assign ram_data = ram_drv ? ram_out_q : 8'hzz;

    always @(posedge clk) begin
        if (ram_cs && ram_rw) ram_mem[ram_addr] <= ram_data;
        if (ram_cs && ram_oe && !ram_rw) ram_out_q <= ram_mem[ram_addr];
        rd_vld_q <= ram_cs && ram_oe && !ram_rw;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bus_idle();
        return (ram_data === 8'hzz) || (ram_data === 8'h00);
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ram_cs && ram_oe && !ram_rw) cnt_rd++;
            if (ram_cs && ram_rw) cnt_wr++;
            chk("ack_overlap", {31'd0, a_ack && b_ack}, 32'd0);
            chk("busy_vs_cs", {31'd0, busy}, {31'd0, ram_cs});
            chk("oe_with_rw", {31'd0, ram_oe && ram_rw}, 32'd0);
            if (ram_drv) begin
                chk("bus_rd_value", {24'd0, ram_data}, {24'd0, ram_out_q});
            end else if (ram_cs && ram_rw) begin
                chk("bus_wr_known", {31'd0, $isunknown(ram_data)}, 32'd0);
            end else begin
                chk("bus_released", {31'd0, bus_idle()}, 32'd1);
            end
        end
    end

    task automatic check_reset();
        chk("rst_cs", {31'd0, ram_cs}, 32'd0);
        chk("rst_rw", {31'd0, ram_rw}, 32'd0);
        chk("rst_oe", {31'd0, ram_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        chk("rst_bus_z", {31'd0, bus_idle()}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset();
        #1 rst = 1'b0;
    endtask

    // Presents one request, waits for its ack and applies it to the memory model.
    task automatic run_one(input bit id, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, output int lat,
                           output logic [7:0] rdata, output logic [7:0] exp_rd);
        bit got;
        got    = 1'b0;
        lat    = 0;
        rdata  = 8'h00;
        exp_rd = 8'h00;
        if (id) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if ((id ? b_ack : a_ack) == 1'b1) got = 1'b1;
        end
        if (id) b_req = 1'b0; else a_req = 1'b0;
        chk("ack_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            rdata  = id ? b_rdata : a_rdata;
            exp_rd = model_mem[addr];
            if (we) model_mem[addr] = wdata;
        end
    endtask

    task automatic client(input bit id);
        bit         we;
        logic [7:0] ad, wd, rd, ex;
        int         lat;
        for (int n = 0; n < 25; n++) begin
            we = 1'($urandom_range(0, 1));
            ad = 8'h40 + 8'($urandom_range(0, 7));
            wd = 8'($urandom);
            run_one(id, we, ad, wd, lat, rd, ex);
            if (!we) chk(id ? "rnd_b_rdata" : "rnd_a_rdata", {24'd0, rd}, {24'd0, ex});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    typedef struct {
        bit         id;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    initial begin
        vec_t       tbl [6];
        int         lat, c_rd, c_wr, a_at, b_at;
        logic [7:0] rd, ex;
        bit         got;
        int         seq [$];

        tbl[0] = '{0, 1, 8'h10, 8'h5A, 8'h00, 2};
        tbl[1] = '{0, 0, 8'h10, 8'h00, 8'h5A, 3};
        tbl[2] = '{0, 1, 8'h11, 8'hC3, 8'h00, 2};
        tbl[3] = '{1, 1, 8'h12, 8'h3C, 8'h00, 2};
        tbl[4] = '{1, 0, 8'h11, 8'h00, 8'hC3, 3};
        tbl[5] = '{0, 0, 8'h12, 8'h00, 8'h3C, 3};
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        #1 rst = 1'b1;
        #1 check_reset();
        #10 rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_rd = cnt_rd;
            c_wr = cnt_wr;
            run_one(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, ex);
            chk("tbl_latency", lat, tbl[i].exp_lat);
            if (tbl[i].we) begin
                chk("tbl_wr_cycles", cnt_wr - c_wr, 1);
            end else begin
                chk("tbl_rdata", {24'd0, rd}, {24'd0, tbl[i].exp_rd});
                chk("tbl_rd_cycles", cnt_rd - c_rd, 2);
            end
            @(negedge clk);
            chk("tbl_ack_pulse", {31'd0, tbl[i].id ? b_ack : a_ack}, 32'd0);
            if (!tbl[i].we)
                chk("tbl_rdata_hold", {24'd0, tbl[i].id ? b_rdata : a_rdata}, {24'd0, tbl[i].exp_rd});
        end

        // Reset lands in WRITE before the commit edge.
        @(negedge clk);
        a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'hFF; a_req = 1'b1;
        @(posedge clk);
        #2 chk("rstw_in_write", {30'd0, ram_cs, ram_rw}, 32'd3);
        rst = 1'b1;
        a_req = 1'b0;
        #1 check_reset();
        #1 rst = 1'b0;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack) got = 1'b1;
        end
        chk("rstw_no_ack", {31'd0, got}, 32'd0);
        @(negedge clk);
        run_one(0, 0, 8'h20, 8'h00, lat, rd, ex);
        chk("rstw_readback", {24'd0, rd}, 32'h00);

        // Simultaneous requests straight after reset: A wins the first tie.
        pulse_reset();
        @(negedge clk);
        a_we = 1'b1; a_addr = 8'h01; a_wdata = 8'h11; a_req = 1'b1;
        b_we = 1'b1; b_addr = 8'h02; b_wdata = 8'h22; b_req = 1'b1;
        a_at = 0;
        b_at = 0;
        for (int n = 1; n <= 20 && (a_at == 0 || b_at == 0); n++) begin
            @(negedge clk);
            if (a_ack && a_at == 0) begin a_at = n; a_req = 1'b0; end
            if (b_ack && b_at == 0) begin b_at = n; b_req = 1'b0; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("sim_a_ack_cycle", a_at, 2);
        chk("sim_b_ack_cycle", b_at, 4);
        model_mem[8'h01] = 8'h11;
        model_mem[8'h02] = 8'h22;
        @(negedge clk);
        run_one(0, 0, 8'h01, 8'h00, lat, rd, ex);
        chk("sim_read_a", {24'd0, rd}, 32'h11);
        @(negedge clk);
        run_one(1, 0, 8'h02, 8'h00, lat, rd, ex);
        chk("sim_read_b", {24'd0, rd}, 32'h22);

        // Continuous read contention: grants must alternate.
        @(negedge clk);
        a_we = 1'b0; a_addr = 8'h01; a_req = 1'b1;
        b_we = 1'b0; b_addr = 8'h02; b_req = 1'b1;
        for (int n = 0; n < 60 && seq.size() < 8; n++) begin
            @(negedge clk);
            if (a_ack) begin
                seq.push_back(0);
                chk("cont_a_rdata", {24'd0, a_rdata}, 32'h11);
            end
            if (b_ack) begin
                seq.push_back(1);
                chk("cont_b_rdata", {24'd0, b_rdata}, 32'h22);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("cont_count", seq.size(), 8);
        if (seq.size() > 0) chk("cont_first", seq[0], 0);
        for (int i = 1; i < seq.size(); i++) chk("cont_alternate", {31'd0, seq[i] == seq[i-1]}, 32'd0);

        // Random mixed traffic from both clients.
        repeat (2) @(negedge clk);
        fork
            client(0);
            client(1);
        join
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
